// File: rtl/robot_pkg.sv
// Shared move codes, opcode/heading/state types and field size for the robot command sequencer.
package robot_pkg;

  localparam logic [2:0] MOVE_STAY  = 3'b000;
  localparam logic [2:0] MOVE_FWD   = 3'b111;
  localparam logic [2:0] MOVE_BWD   = 3'b011;
  localparam logic [2:0] MOVE_LEFT  = 3'b101;
  localparam logic [2:0] MOVE_RIGHT = 3'b110;

  localparam int FIELD_SIZE = 7;

  typedef enum logic [1:0] {
    OP_FWD   = 2'b00,
    OP_BWD   = 2'b01,
    OP_LEFT  = 2'b10,
    OP_RIGHT = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    HD_W = 2'b00,
    HD_N = 2'b01,
    HD_E = 2'b10,
    HD_S = 2'b11
  } heading_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  function automatic logic [2:0] move_code(input opcode_e op);
    case (op)
      OP_FWD:  move_code = MOVE_FWD;
      OP_BWD:  move_code = MOVE_BWD;
      OP_LEFT: move_code = MOVE_LEFT;
      default: move_code = MOVE_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/robot_cmd_sequencer_if.sv
// Valid/ready command channel between a command producer and the sequencer.
interface robot_cmd_sequencer_if;
  import robot_pkg::*;

  logic    cmd_valid;
  opcode_e cmd;
  logic    cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);

endinterface

// File: rtl/robot_cmd_fifo.sv
// Small first-word-fall-through command FIFO; head is visible combinationally for evaluation.
module robot_cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       push_i,
  input  logic [1:0] din_i,
  input  logic       pop_i,
  output logic [1:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_wr_en;
  logic        w_rd_en;

  assign w_wr_en = push_i && !full_o;
  assign w_rd_en = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din_i;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout_o  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/robot_cmd_sequencer.sv
// Buffers motion commands, validates them against the 7x7 field and obstacles,
// and issues each legal one as a single-cycle move code followed by a STAY gap.
module robot_cmd_sequencer
  import robot_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [2:0]  X0    = 3'd5,
  parameter logic [2:0]  Y0    = 3'd1,
  parameter logic [1:0]  H0    = 2'b01
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        enable_i,
  robot_cmd_sequencer_if.slave        cmd_if,
  input  logic                        clr_err_i,
  input  logic                        motor_status_i,
  input  logic                        tracker_status_i,
  output logic                        motor_on_o,
  output logic [2:0]                  move_o,
  output logic [2:0]                  pos_x_o,
  output logic [2:0]                  pos_y_o,
  output logic [1:0]                  heading_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [7:0]                  reject_cnt_o
);

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_move_code;
  logic [2:0] r_pos_x;
  logic [2:0] r_pos_y;
  heading_e   r_heading;
  logic       r_motor_on;
  logic       r_err;
  logic [7:0] r_reject_cnt;

  logic [1:0] w_head;
  logic       w_full;
  logic       w_empty;
  opcode_e    w_op;
  logic [3:0] w_dx;
  logic [3:0] w_dy;
  logic [3:0] w_tx;
  logic [3:0] w_ty;
  logic       w_in_field;
  logic       w_legal;
  logic       w_pop;
  logic       w_accept;
  logic       w_reject;

  robot_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (cmd_if.cmd_valid),
    .din_i   (cmd_if.cmd),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign cmd_if.cmd_ready = !w_full;
  assign w_op = opcode_e'(w_head);

  // Unit step along the heading in 4-bit two's complement; a -1 from 0 wraps to 15 and fails the range test.
  always_comb begin
    w_dx = 4'd0;
    w_dy = 4'd0;
    case (r_heading)
      HD_W:    w_dx = 4'hF;
      HD_N:    w_dy = 4'd1;
      HD_E:    w_dx = 4'd1;
      default: w_dy = 4'hF;
    endcase
    if (w_op == OP_BWD) begin
      w_dx = 4'd0 - w_dx;
      w_dy = 4'd0 - w_dy;
    end
  end

  assign w_tx       = {1'b0, r_pos_x} + w_dx;
  assign w_ty       = {1'b0, r_pos_y} + w_dy;
  assign w_in_field = (w_tx < 4'(FIELD_SIZE)) && (w_ty < 4'(FIELD_SIZE));
  assign w_legal    = (w_op == OP_LEFT) || (w_op == OP_RIGHT) ||
                      (w_in_field && !((w_op == OP_FWD) && tracker_status_i));

  assign w_pop    = (r_state == ST_IDLE) && !w_empty && motor_status_i;
  assign w_accept = w_pop && w_legal;
  assign w_reject = w_pop && !w_legal;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_GAP;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    move_o = MOVE_STAY;
    if (r_state == ST_ISSUE) move_o = r_move_code;
    busy_o = (r_state != ST_IDLE) || !w_empty;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_move_code  <= MOVE_STAY;
      r_pos_x      <= X0;
      r_pos_y      <= Y0;
      r_heading    <= heading_e'(H0);
      r_motor_on   <= 1'b0;
      r_err        <= 1'b0;
      r_reject_cnt <= 8'd0;
    end else begin
      r_motor_on <= enable_i;
      if (w_accept) begin
        r_move_code <= move_code(w_op);
        case (w_op)
          OP_LEFT:  r_heading <= heading_e'(r_heading - 2'd1);
          OP_RIGHT: r_heading <= heading_e'(r_heading + 2'd1);
          default: begin
            r_pos_x <= w_tx[2:0];
            r_pos_y <= w_ty[2:0];
          end
        endcase
      end
      // Clear wins over a rejection landing in the same cycle.
      if (clr_err_i)     r_err <= 1'b0;
      else if (w_reject) r_err <= 1'b1;
      if (w_reject && (r_reject_cnt != 8'hFF)) r_reject_cnt <= r_reject_cnt + 8'd1;
    end
  end

  assign motor_on_o   = r_motor_on;
  assign pos_x_o      = r_pos_x;
  assign pos_y_o      = r_pos_y;
  assign heading_o    = r_heading;
  assign err_o        = r_err;
  assign reject_cnt_o = r_reject_cnt;

endmodule

// File: tb/tb_robot_cmd_sequencer.sv
// Directed and randomized checks of robot_cmd_sequencer against a pose/queue reference model.
module tb_robot_cmd_sequencer;
  import robot_pkg::*;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic       motor_status_i = 1'b0;
  logic       tracker_status_i = 1'b0;
  logic       motor_on_o;
  logic [2:0] move_o;
  logic [2:0] pos_x_o;
  logic [2:0] pos_y_o;
  logic [1:0] heading_o;
  logic       busy_o;
  logic       err_o;
  logic [7:0] reject_cnt_o;

  robot_cmd_sequencer_if if_cmd ();

  robot_cmd_sequencer #(.DEPTH(4), .X0(3'd5), .Y0(3'd1), .H0(2'b01)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .enable_i         (enable_i),
    .cmd_if           (if_cmd),
    .clr_err_i        (clr_err_i),
    .motor_status_i   (motor_status_i),
    .tracker_status_i (tracker_status_i),
    .motor_on_o       (motor_on_o),
    .move_o           (move_o),
    .pos_x_o          (pos_x_o),
    .pos_y_o          (pos_y_o),
    .heading_o        (heading_o),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .reject_cnt_o     (reject_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pose on the field, sticky error, saturating reject counter.
  int m_x, m_y, m_h, m_cnt;
  bit m_err;
  logic [2:0] codes [4] = '{3'b111, 3'b011, 3'b101, 3'b110};
  logic [2:0] exp_q [$];
  int fill_q [$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    m_x = 5; m_y = 1; m_h = 1; m_cnt = 0; m_err = 0;
  endfunction

  // Applies one popped command; returns its move code, or 0 when rejected.
  function automatic logic [2:0] model_exec(input int c, input bit trk, input bit clr);
    int dx, dy, nx, ny;
    bit legal;
    dx = (m_h == 2) ? 1 : (m_h == 0) ? -1 : 0;
    dy = (m_h == 1) ? 1 : (m_h == 3) ? -1 : 0;
    nx = m_x; ny = m_y;
    if (c == 0) begin nx = m_x + dx; ny = m_y + dy; end
    if (c == 1) begin nx = m_x - dx; ny = m_y - dy; end
    legal = (nx >= 0) && (nx <= 6) && (ny >= 0) && (ny <= 6) && !(c == 0 && trk);
    if (clr) m_err = 0;
    if (legal) begin
      m_x = nx; m_y = ny;
      if (c == 2) m_h = (m_h + 3) % 4;
      if (c == 3) m_h = (m_h + 1) % 4;
      return codes[c];
    end
    if (!clr) m_err = 1;
    if (m_cnt < 255) m_cnt++;
    return 3'b000;
  endfunction

  function automatic void build_seq(input logic [2:0] code);
    exp_q.push_back(code);
    if (code != 3'b000) begin
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b000);
    end
  endfunction

  task automatic chk_pose(input string tag);
    chk({tag, "_x"}, pos_x_o, m_x);
    chk({tag, "_y"}, pos_y_o, m_y);
    chk({tag, "_h"}, heading_o, m_h);
    chk({tag, "_err"}, err_o, m_err);
    chk({tag, "_cnt"}, reject_cnt_o, m_cnt);
  endtask

  // Push one command into an empty, idle sequencer and follow it to completion.
  task automatic run_cmd(input int c, input bit trk, input bit clr);
    logic [2:0] code;
    code = model_exec(c, trk, clr);
    tracker_status_i = trk;
    clr_err_i = clr;
    if_cmd.cmd_valid = 1'b1;
    if_cmd.cmd = opcode_e'(c[1:0]);
    tick();
    if_cmd.cmd_valid = 1'b0;
    tick();
    tracker_status_i = 1'b0;
    clr_err_i = 1'b0;
    chk("run_move", move_o, code);
    chk_pose("run");
    if (code != 3'b000) begin
      chk("run_busy_issue", busy_o, 1);
      tick();
      chk("run_gap", move_o, 0);
      tick();
    end
    chk("run_idle_busy", busy_o, 0);
    $display("cmd=%0d trk=%0d clr=%0d move=%b pose=(%0d,%0d) h=%0d err=%0d cnt=%0d",
             c, trk, clr, code, pos_x_o, pos_y_o, heading_o, err_o, reject_cnt_o);
  endtask

  initial begin
    int prog [4];
    int fill [5];
    logic [2:0] code;
    if_cmd.cmd_valid = 1'b0;
    if_cmd.cmd = OP_FWD;
    model_reset();

    // Reset values
    #2 rstn_i = 1'b0;
    tick(); tick();
    chk("rst_move", move_o, 0);
    chk("rst_motor_on", motor_on_o, 0);
    chk("rst_ready", if_cmd.cmd_ready, 1);
    chk("rst_busy", busy_o, 0);
    chk_pose("rst");
    enable_i = 1'b1;
    motor_status_i = 1'b1;
    tick();
    rstn_i = 1'b1;
    tick();
    chk("motor_on", motor_on_o, 1);

    // Back-to-back FWD, FWD, LEFT, FWD
    prog = '{0, 0, 2, 0};
    exp_q.delete();
    foreach (prog[i]) build_seq(model_exec(prog[i], 0, 0));
    while (exp_q.size() < 12) exp_q.push_back(3'b000);
    for (int k = 0; k < 13; k++) begin
      if (k < 4) begin
        if_cmd.cmd_valid = 1'b1;
        if_cmd.cmd = opcode_e'(prog[k][1:0]);
      end else begin
        if_cmd.cmd_valid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        code = exp_q.pop_front();
        chk("seq_move", move_o, code);
        $display("seq cycle %0d move=%b", k, move_o);
      end
    end
    chk("seq_final_x", pos_x_o, 4);
    chk("seq_final_y", pos_y_o, 3);
    chk("seq_final_h", heading_o, 0);
    chk_pose("seq");

    // Walk to (5,6) facing N, then FWD must be rejected by the field edge
    run_cmd(3, 0, 0); run_cmd(0, 0, 0); run_cmd(0, 0, 0); run_cmd(0, 0, 0);
    run_cmd(3, 0, 0); run_cmd(0, 0, 0); run_cmd(2, 0, 0);
    chk("edge_x", pos_x_o, 5);
    chk("edge_y", pos_y_o, 6);
    run_cmd(0, 0, 0);
    chk("edge_err", err_o, 1);
    chk("edge_cnt", reject_cnt_o, 1);

    // Clear alone, then clear colliding with a rejection
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    m_err = 0;
    chk("clr_err", err_o, 0);
    run_cmd(0, 0, 1);
    chk("clr_same_err", err_o, 0);
    chk("clr_same_cnt", reject_cnt_o, 2);

    // Obstacle blocks FWD; RIGHT still issues
    run_cmd(1, 0, 0);
    run_cmd(0, 1, 0);
    run_cmd(3, 1, 0);
    chk("trk_heading", heading_o, 2);

    // Motor not ready: fill FIFO, fifth push refused, then drain in order
    motor_status_i = 1'b0;
    fill = '{2, 1, 1, 3, 0};
    fill_q.delete();
    foreach (fill[i]) begin
      chk("fill_ready", if_cmd.cmd_ready, (fill_q.size() < 4) ? 1 : 0);
      if_cmd.cmd_valid = 1'b1;
      if_cmd.cmd = opcode_e'(fill[i][1:0]);
      tick();
      if (fill_q.size() < 4) fill_q.push_back(fill[i]);
      chk("fill_move", move_o, 0);
      $display("fill push %0d cmd=%0d ready=%0d", i, fill[i], if_cmd.cmd_ready);
    end
    if_cmd.cmd_valid = 1'b0;
    chk("fill_full", if_cmd.cmd_ready, 0);
    chk("fill_busy", busy_o, 1);
    exp_q.delete();
    foreach (fill_q[i]) build_seq(model_exec(fill_q[i], 0, 0));
    while (exp_q.size() < 12) exp_q.push_back(3'b000);
    motor_status_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      code = exp_q.pop_front();
      chk("drain_move", move_o, code);
      $display("drain cycle %0d move=%b", k, move_o);
    end
    chk("drain_busy", busy_o, 0);
    chk_pose("drain");

    // Reset while ISSUE with a second command queued
    if_cmd.cmd_valid = 1'b1;
    if_cmd.cmd = OP_FWD;
    code = model_exec(0, 0, 0);
    tick();
    if_cmd.cmd = OP_LEFT;
    tick();
    if_cmd.cmd_valid = 1'b0;
    chk("rstiss_move", move_o, code);
    #2 rstn_i = 1'b0;
    #1;
    model_reset();
    chk("rstiss_move0", move_o, 0);
    chk("rstiss_busy", busy_o, 0);
    chk("rstiss_ready", if_cmd.cmd_ready, 1);
    chk_pose("rstiss");
    $display("reset during issue: move=%b pose=(%0d,%0d) busy=%0d", move_o, pos_x_o, pos_y_o, busy_o);
    tick();
    rstn_i = 1'b1;
    tick();

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      run_cmd(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    // Rejections at one per cycle until the counter saturates
    tracker_status_i = 1'b1;
    if_cmd.cmd_valid = 1'b1;
    if_cmd.cmd = OP_FWD;
    for (int i = 0; i < 260; i++) begin
      code = model_exec(0, 1, 0);
      tick();
    end
    if_cmd.cmd_valid = 1'b0;
    tick();
    tracker_status_i = 1'b0;
    chk("sat_cnt", reject_cnt_o, 255);
    chk("sat_busy", busy_o, 0);
    chk_pose("sat");
    $display("saturation: cnt=%0d err=%0d", reject_cnt_o, err_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
